// File: rtl/demux1x2_pipe_if.sv
// Handshake bundle for the 1:2 pipelined demux: one tagged input stream, two output streams.
// Latency: n/a (wires only).
// Backpressure: in_ready, a_ready and b_ready carry stall information against the data direction.
// Ports: in_data/in_sel/in_valid/in_ready (source side), a_*/b_* (destination sides).
interface demux1x2_pipe_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;

    // Environment side: drives the input stream and the destination readies.
    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid
    );

    // Demux side.
    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid
    );
endinterface

// File: rtl/demux1x2_pipe.sv
// Pipelined 1:2 demux steering each tagged word to output A (sel=0) or B (sel=1).
// Latency: 2 edges with no stall (stage-1 register, then output register).
// Backpressure: a stalled destination holds its output and blocks stage 1, hence all input.
// Ports: clk, rst_n (async active-low), bus (slave modport: in_*, a_*, b_* handshakes).
module demux1x2_pipe #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    demux1x2_pipe_if.slave    bus
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic             s1_sel_q,   s1_sel_d;
    logic             a_valid_q,  a_valid_d;
    logic [WIDTH-1:0] a_data_q,   a_data_d;
    logic             b_valid_q,  b_valid_d;
    logic [WIDTH-1:0] b_data_q,   b_data_d;

    logic can_load_a;
    logic can_load_b;
    logic s1_go;
    logic in_ready;
    logic in_fire;

    always_comb begin
        // An output register may take a new word when empty or being emptied this edge.
        can_load_a = !a_valid_q || bus.a_ready;
        can_load_b = !b_valid_q || bus.b_ready;
        s1_go      = s1_valid_q && (s1_sel_q ? can_load_b : can_load_a);
        // Depends only on registered state and the destination readies, never on in_valid.
        in_ready   = !s1_valid_q || s1_go;
        in_fire    = bus.in_valid && in_ready;

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_sel_d   = s1_sel_q;
        a_valid_d  = a_valid_q;
        a_data_d   = a_data_q;
        b_valid_d  = b_valid_q;
        b_data_d   = b_data_q;

        // Load takes priority over drain so stage 1 can drain and refill on the same edge.
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = bus.in_data;
            s1_sel_d   = bus.in_sel;
        end else if (s1_go) begin
            s1_valid_d = 1'b0;
        end

        if (s1_go && !s1_sel_q) begin
            a_valid_d = 1'b1;
            a_data_d  = s1_data_q;
        end else if (bus.a_ready) begin
            a_valid_d = 1'b0;
        end

        if (s1_go && s1_sel_q) begin
            b_valid_d = 1'b1;
            b_data_d  = s1_data_q;
        end else if (bus.b_ready) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sel_q   <= 1'b0;
            a_valid_q  <= 1'b0;
            a_data_q   <= '0;
            b_valid_q  <= 1'b0;
            b_data_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_sel_q   <= s1_sel_d;
            a_valid_q  <= a_valid_d;
            a_data_q   <= a_data_d;
            b_valid_q  <= b_valid_d;
            b_data_q   <= b_data_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.a_valid  = a_valid_q;
    assign bus.a_data   = a_data_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.b_data   = b_data_q;

endmodule
